// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter: FSM state
// encoding and the double-dabble digit-adjust parameters.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction: a digit of 5 or more gets +3 (mod 16)
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= DIGIT_W'(ADJ_THRESH)) ? i_digit + DIGIT_W'(ADJ_ADD)
                                                       : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble shift per clock, with
// valid/ready on both sides. Define BCD_SIGNED_EN for two's-complement input.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BIN_W-1:0]           in_bin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIGIT_W*DIGITS-1:0]  out_bcd,
    output logic                       out_ovf,
    output logic                       out_neg
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = DIGIT_W * DIGITS;

    state_t             r_state;
    state_t             w_stateNext;
    logic [BIN_W-1:0]   r_binSr;
    logic [BCD_W-1:0]   r_bcdAcc;
    logic [BCD_W-1:0]   w_bcdAdj;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_inReady;
    logic               r_outValid;
    logic [BCD_W-1:0]   r_outBcd;
    logic               r_outOvf;
    logic [BIN_W-1:0]   w_loadMag;
    logic               w_accept;
    logic               w_step;
    logic               w_present;
    logic               w_release;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_bcdAcc[g*DIGIT_W +: DIGIT_W]),
                .o_digit (w_bcdAdj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

`ifdef BCD_SIGNED_EN
    logic r_neg;
    logic r_outNeg;

    // The most negative value negates to itself, which is the correct unsigned magnitude.
    assign w_loadMag = in_bin[BIN_W-1] ? (BIN_W'(0) - in_bin) : in_bin;
`else
    assign w_loadMag = in_bin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)                  w_stateNext = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CNT_W'(BIN_W - 1)) w_stateNext = ST_DONE;
            ST_DONE:  if (r_outValid && out_ready)   w_stateNext = ST_IDLE;
            default:                                 w_stateNext = ST_IDLE;
        endcase
    end

    // The first DONE cycle copies the finished accumulator into the output
    // registers; the result is then held until the downstream handshake.
    always_comb begin
        w_accept  = (r_state == ST_IDLE) && in_valid;
        w_step    = (r_state == ST_SHIFT);
        w_present = (r_state == ST_DONE) && !r_outValid;
        w_release = (r_state == ST_DONE) && r_outValid && out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_binSr  <= '0;
            r_bcdAcc <= '0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_binSr  <= w_loadMag;
            r_bcdAcc <= '0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_bcdAcc <= {w_bcdAdj[BCD_W-2:0], r_binSr[BIN_W-1]};
            r_binSr  <= {r_binSr[BIN_W-2:0], 1'b0};
            r_ovf    <= r_ovf | w_bcdAdj[BCD_W-1];
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_outBcd   <= '0;
            r_outOvf   <= 1'b0;
        end else begin
            r_inReady <= (w_stateNext == ST_IDLE);
            if (w_present) begin
                r_outValid <= 1'b1;
                r_outBcd   <= r_bcdAcc;
                r_outOvf   <= r_ovf;
            end else if (w_release) begin
                r_outValid <= 1'b0;
            end
        end
    end

`ifdef BCD_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg    <= 1'b0;
            r_outNeg <= 1'b0;
        end else begin
            if (w_accept) begin
                r_neg <= in_bin[BIN_W-1];
            end
            if (w_present) begin
                r_outNeg <= r_neg;
            end
        end
    end

    assign out_neg = r_outNeg;
`else
    assign out_neg = 1'b0;
`endif

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_bcd   = r_outBcd;
    assign out_ovf   = r_outOvf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 3-digit and a 2-digit instance share
// stimulus and are compared every cycle against an arithmetic model.
module tb_bin2bcd_seq;

    localparam int BIN_W   = 8;
    localparam int DIGITS  = 3;
    localparam int DIGITS2 = 2;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_bin    = 8'd0;

    logic        in_ready,  out_valid,  out_ovf,  out_neg;
    logic        in_ready2, out_valid2, out_ovf2, out_neg2;
    logic [11:0] out_bcd;
    logic [7:0]  out_bcd2;

    int          vectors = 0;
    int          errors  = 0;
    int          cycle   = 0;
    int          acceptEdge = 0;
    logic [7:0]  pending[$];

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bin(in_bin), .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_ovf(out_ovf), .out_neg(out_neg)
    );

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_bin(in_bin), .out_valid(out_valid2), .out_ready(out_ready),
        .out_bcd(out_bcd2), .out_ovf(out_ovf2), .out_neg(out_neg2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decimal digits by plain division; overflow means something is left over.
    function automatic void modelConv(input logic [7:0] v, input int digits,
                                      output logic [63:0] bcd, output logic ovf,
                                      output logic neg);
        longint mag;
        mag = longint'(v);
        neg = 1'b0;
`ifdef BCD_SIGNED_EN
        if (v[7]) begin
            neg = 1'b1;
            mag = (longint'(1) << BIN_W) - longint'(v);
        end
`endif
        bcd = 64'd0;
        for (int i = 0; i < digits; i++) begin
            bcd |= 64'(mag % 10) << (4 * i);
            mag = mag / 10;
        end
        ovf = (mag != 0);
    endfunction

    always @(negedge clk) begin
        logic [63:0] eBcd;
        logic        eOvf, eNeg, expValid;
        if (!rst_n) begin
            pending.delete();
            checkOutput("rstInReady",  64'(in_ready),  64'd1);
            checkOutput("rstOutValid", 64'(out_valid), 64'd0);
            checkOutput("rstOutBcd",   64'(out_bcd),   64'd0);
            checkOutput("rstOutOvf",   64'(out_ovf),   64'd0);
            checkOutput("rstOutNeg",   64'(out_neg),   64'd0);
            checkOutput("rstOutValid2", 64'(out_valid2), 64'd0);
        end else begin
            expValid = (pending.size() > 0) && (cycle - acceptEdge >= BIN_W + 1);
            checkOutput("outValid",  64'(out_valid),  64'(expValid));
            checkOutput("outValid2", 64'(out_valid2), 64'(expValid));
            checkOutput("inReady",   64'(in_ready),   64'(pending.size() == 0));
            checkOutput("inReady2",  64'(in_ready2),  64'(pending.size() == 0));
            if (out_valid && pending.size() > 0) begin
                modelConv(pending[0], DIGITS, eBcd, eOvf, eNeg);
                checkOutput("outBcd", 64'(out_bcd), eBcd);
                checkOutput("outOvf", 64'(out_ovf), 64'(eOvf));
                checkOutput("outNeg", 64'(out_neg), 64'(eNeg));
                modelConv(pending[0], DIGITS2, eBcd, eOvf, eNeg);
                checkOutput("outBcd2", 64'(out_bcd2), eBcd);
                checkOutput("outOvf2", 64'(out_ovf2), 64'(eOvf));
                checkOutput("outNeg2", 64'(out_neg2), 64'(eNeg));
                if (out_ready) void'(pending.pop_front());
            end
            if (in_valid && in_ready) begin
                pending.push_back(in_bin);
                acceptEdge = cycle + 1;
            end
        end
    end

    // Offers one word, then holds out_ready low for 'hold' cycles once the
    // result appears; returns the captured result and the observed latency.
    task automatic applyStimulus(input logic [7:0] v, input int hold,
                                 output logic [11:0] bcd, output logic ovf,
                                 output logic [7:0] bcd2, output logic ovf2,
                                 output logic neg, output int latency);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("idleTimeout", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_bin    = v;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bin   = 8'($urandom);
        latency  = 0;
        while (!out_valid && latency < 40) begin
            @(posedge clk); #1;
            latency++;
        end
        checkOutput("resultTimeout", 64'(out_valid), 64'd1);
        bcd  = out_bcd;
        ovf  = out_ovf;
        bcd2 = out_bcd2;
        ovf2 = out_ovf2;
        neg  = out_neg;
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic runDirected(input logic [7:0] v, input int hold,
                               input logic [11:0] eBcd, input logic eOvf,
                               input logic [7:0] eBcd2, input logic eOvf2,
                               input logic eNeg);
        logic [11:0] bcd;
        logic [7:0]  bcd2;
        logic        ovf, ovf2, neg;
        int          lat;
        applyStimulus(v, hold, bcd, ovf, bcd2, ovf2, neg, lat);
        checkOutput("litBcd",     64'(bcd),  64'(eBcd));
        checkOutput("litOvf",     64'(ovf),  64'(eOvf));
        checkOutput("litBcd2",    64'(bcd2), 64'(eBcd2));
        checkOutput("litOvf2",    64'(ovf2), 64'(eOvf2));
        checkOutput("litNeg",     64'(neg),  64'(eNeg));
        checkOutput("litLatency", 64'(lat),  64'd9);
    endtask

    task automatic midReset(input logic [7:0] v);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid  = 1'b1;
        in_bin    = v;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abortOutValid", 64'(out_valid), 64'd0);
        checkOutput("abortInReady",  64'(in_ready),  64'd1);
        checkOutput("abortOutBcd",   64'(out_bcd),   64'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [11:0] bcd;
        logic [7:0]  bcd2;
        logic        ovf, ovf2, neg;
        int          lat;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef BCD_SIGNED_EN
        runDirected(8'h80, 0, 12'h128, 1'b0, 8'h28, 1'b1, 1'b1);
        runDirected(8'hFF, 0, 12'h001, 1'b0, 8'h01, 1'b0, 1'b1);
        runDirected(8'h7F, 0, 12'h127, 1'b0, 8'h27, 1'b1, 1'b0);
        runDirected(8'd0,  0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0);
        runDirected(8'd99, 5, 12'h099, 1'b0, 8'h99, 1'b0, 1'b0);
`else
        runDirected(8'd255, 0, 12'h255, 1'b0, 8'h55, 1'b1, 1'b0);
        runDirected(8'd0,   0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0);
        runDirected(8'd9,   0, 12'h009, 1'b0, 8'h09, 1'b0, 1'b0);
        runDirected(8'd200, 0, 12'h200, 1'b0, 8'h00, 1'b1, 1'b0);
        runDirected(8'd99,  0, 12'h099, 1'b0, 8'h99, 1'b0, 1'b0);
        runDirected(8'd173, 5, 12'h173, 1'b0, 8'h73, 1'b1, 1'b0);
`endif

        midReset(8'd250);
        runDirected(8'd42, 0, 12'h042, 1'b0, 8'h42, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(8'($urandom), int'($urandom_range(0, 3)),
                          bcd, ovf, bcd2, ovf2, neg, lat);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: simulation did not complete, expected completion");
        $fatal(1, "[TB] aborted");
    end

endmodule
